// File: rtl/riscv_imm_pkg.sv
// Shared RV32I immediate encoding constants used by both the encode and decode paths.
package riscv_imm_pkg;

  localparam logic IMM_SRC_I = 1'b0;
  localparam logic IMM_SRC_S = 1'b1;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  localparam int FUNCT3_W = 3;
  localparam int OPCODE_W = 7;
  localparam int CNT_W    = 16;

  typedef logic [XLEN-1:0] word_t;

  // A 12-bit signed immediate fits when bits 31..11 are a pure sign extension.
  function automatic logic imm_fits12(input word_t imm);
    return (&imm[31:11]) || !(|imm[31:11]);
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational I/S-type instruction field packer with 12-bit range flag.
module imm_field_pack
  import riscv_imm_pkg::*;
(
  input  logic                imm_src,
  input  word_t               imm,
  input  logic [REG_W-1:0]    rs1,
  input  logic [REG_W-1:0]    rd_rs2,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [OPCODE_W-1:0] opcode,
  output word_t               instr,
  output logic                in_range
);

  always_comb begin
    instr = '0;
    if (imm_src == IMM_SRC_S)
      instr = {imm[11:5], rd_rs2, rs1, funct3, imm[4:0], opcode};
    else
      instr = {imm[11:0], rs1, funct3, rd_rs2, opcode};
  end

  assign in_range = imm_fits12(imm);

endmodule

// File: rtl/imm_encoder.sv
// Two-stage pipelined RV32I I/S-type immediate encoder with valid/ready streaming.
// Optional out-of-range rejection is enabled by defining IMM_RANGE_CHECK_EN.
module imm_encoder
  import riscv_imm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_imm_src,
  input  word_t               in_imm,
  input  logic [REG_W-1:0]    in_rs1,
  input  logic [REG_W-1:0]    in_rd_rs2,
  input  logic [FUNCT3_W-1:0] in_funct3,
  input  logic [OPCODE_W-1:0] in_opcode,
  output logic                out_valid,
  input  logic                out_ready,
  output word_t               out_instr,
  output logic                out_imm_src,
  output logic                err_valid,
  output word_t               err_imm,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    enc_count,
  output logic [CNT_W-1:0]    rej_count
);

`ifdef IMM_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  word_t pack_instr;
  logic  pack_in_range;

  logic  s1_valid, s1_rej, s1_src;
  word_t s1_instr, s1_imm;
  logic  s2_valid, s2_src;
  word_t s2_instr;

  logic  s1_moves, accept, s1_to_s2, out_fire;

  imm_field_pack u_pack (
    .imm_src  (in_imm_src),
    .imm      (in_imm),
    .rs1      (in_rs1),
    .rd_rs2   (in_rd_rs2),
    .funct3   (in_funct3),
    .opcode   (in_opcode),
    .instr    (pack_instr),
    .in_range (pack_in_range)
  );

  // A reject never waits on S2, so it always drains.
  assign s1_moves = s1_rej || !s2_valid || out_ready;
  assign in_ready = !s1_valid || s1_moves;
  assign accept   = in_valid && in_ready;
  assign s1_to_s2 = s1_valid && !s1_rej && s1_moves;
  assign out_fire = s2_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_rej   <= 1'b0;
      s1_src   <= 1'b0;
      s1_instr <= '0;
      s1_imm   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_rej   <= RANGE_CHECK && !pack_in_range;
      s1_src   <= in_imm_src;
      s1_instr <= pack_instr;
      s1_imm   <= in_imm;
    end else if (s1_valid && s1_moves) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_src   <= 1'b0;
      s2_instr <= '0;
    end else if (s1_to_s2) begin
      s2_valid <= 1'b1;
      s2_src   <= s1_src;
      s2_instr <= s1_instr;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid   = s2_valid;
  assign out_instr   = s2_instr;
  assign out_imm_src = s2_src;
  assign err_valid   = s1_valid && s1_rej;
  assign err_imm     = err_valid ? s1_imm : '0;

  // Clear takes priority over a coincident increment; both counters saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
      rej_count <= '0;
    end else begin
      if (cnt_clr)
        enc_count <= '0;
      else if (out_fire && enc_count != '1)
        enc_count <= enc_count + 1'b1;

      if (cnt_clr)
        rej_count <= '0;
      else if (err_valid && rej_count != '1)
        rej_count <= rej_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table plus backpressure, streaming and reset sequences.
module tb_imm_encoder;
  import riscv_imm_pkg::*;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_imm_src;
  logic [31:0] in_imm;
  logic [4:0]  in_rs1, in_rd_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_opcode;
  logic        out_valid, out_ready, out_imm_src;
  logic [31:0] out_instr;
  logic        err_valid;
  logic [31:0] err_imm;
  logic        cnt_clr;
  logic [15:0] enc_count, rej_count;

  imm_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm_src(in_imm_src),
    .in_imm(in_imm), .in_rs1(in_rs1), .in_rd_rs2(in_rd_rs2),
    .in_funct3(in_funct3), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm_src(out_imm_src), .err_valid(err_valid), .err_imm(err_imm),
    .cnt_clr(cnt_clr), .enc_count(enc_count), .rej_count(rej_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        src;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rr;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] exp_instr;
    logic        oor;
  } vec_t;

  vec_t vecs[7];
  vec_t exp_q[$];

  task automatic drive(input vec_t v);
    in_valid   = 1'b1;
    in_imm_src = v.src;
    in_imm     = v.imm;
    in_rs1     = v.rs1;
    in_rd_rs2  = v.rr;
    in_funct3  = v.f3;
    in_opcode  = v.op;
  endtask

  // Inverse view of an encoded word: sign-extended immediate and fields.
  function automatic logic [52:0] decode(input logic [31:0] w, input logic src);
    logic [31:0] imm;
    logic [4:0]  rr;
    if (src) begin
      imm = {{20{w[31]}}, w[31:25], w[11:7]};
      rr  = w[24:20];
    end else begin
      imm = {{20{w[31]}}, w[31:20]};
      rr  = w[11:7];
    end
    return {imm, w[19:15], rr, w[14:12], w[6:0], src};
  endfunction

  function automatic logic [52:0] fields(input vec_t v);
    return {v.imm, v.rs1, v.rr, v.f3, v.op, v.src};
  endfunction

  initial begin
    int exp_enc, exp_rej, got, sent;
    logic rej, acc;
    vec_t v, e;

    vecs[0] = '{1'b0, 32'hFFFF_FFFF, 5'd2,  5'd1,  3'd0, OPC_OP_IMM, 32'hFFF1_0093, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0008, 5'd2,  5'd5,  3'd2, OPC_STORE,  32'h0051_2423, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0800, 5'd0,  5'd0,  3'd0, OPC_OP_IMM, 32'h8000_0013, 1'b1};
    vecs[3] = '{1'b0, 32'hFFFF_F800, 5'd4,  5'd3,  3'd2, OPC_LOAD,   32'h8002_2183, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_07FF, 5'd0,  5'd31, 3'd2, OPC_STORE,  32'h7FF0_2FA3, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_F7FF, 5'd1,  5'd1,  3'd0, OPC_STORE,  32'h7E10_8FA3, 1'b1};
    vecs[6] = '{1'b0, 32'h0000_07FF, 5'd31, 5'd31, 3'd7, OPC_OP_IMM, 32'h7FFF_FF93, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    in_imm_src = 1'b0; in_imm = '0; in_rs1 = '0; in_rd_rs2 = '0; in_funct3 = '0; in_opcode = '0;
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_instr", out_instr, 0);
    check("rst out_imm_src", out_imm_src, 0);
    check("rst err_valid", err_valid, 0);
    check("rst err_imm", err_imm, 0);
    check("rst enc_count", enc_count, 0);
    check("rst rej_count", rej_count, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed table, one entry at a time with no backpressure.
    exp_enc = 0; exp_rej = 0;
    foreach (vecs[k]) begin
      rej = CHK && vecs[k].oor;
      @(posedge clk); #1;
      drive(vecs[k]);
      check($sformatf("vec%0d in_ready", k), in_ready, 1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d err_valid", k), err_valid, rej);
      if (rej) check($sformatf("vec%0d err_imm", k), err_imm, vecs[k].imm);
      @(negedge clk);
      check($sformatf("vec%0d out_valid", k), out_valid, !rej);
      check($sformatf("vec%0d err_clear", k), err_valid, 0);
      if (!rej) begin
        check($sformatf("vec%0d out_instr", k), out_instr, vecs[k].exp_instr);
        check($sformatf("vec%0d out_imm_src", k), out_imm_src, vecs[k].src);
      end
      if (rej) exp_rej++; else exp_enc++;
    end
    @(posedge clk); #1;
    check("table enc_count", enc_count, exp_enc);
    check("table rej_count", rej_count, exp_rej);

    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    check("clr enc_count", enc_count, 0);
    check("clr rej_count", rej_count, 0);

    // Clear coinciding with a delivery leaves the counter at zero.
    drive(vecs[0]);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 cnt_clr = 1'b1;
    check("clrwin out_valid", out_valid, 1);
    @(posedge clk); #1 cnt_clr = 1'b0;
    check("clrwin enc_count", enc_count, 0);

    // Backpressure: three back-to-back entries with out_ready low.
    out_ready = 1'b0;
    drive(vecs[0]);
    check("bp in_ready A", in_ready, 1);
    @(posedge clk); #1;
    drive(vecs[1]);
    check("bp in_ready B", in_ready, 1);
    @(posedge clk); #1;
    drive(vecs[3]);
    check("bp in_ready full", in_ready, 0);
    check("bp out_instr A", out_instr, vecs[0].exp_instr);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("bp hold in_ready", in_ready, 0);
      check("bp hold out_instr", out_instr, vecs[0].exp_instr);
      check("bp hold out_imm_src", out_imm_src, vecs[0].src);
    end
    out_ready = 1'b1;
    exp_q.delete();
    exp_q.push_back(vecs[0]); exp_q.push_back(vecs[1]); exp_q.push_back(vecs[3]);
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (out_valid) begin
        e = exp_q.pop_front();
        check($sformatf("bp word%0d", got), out_instr, e.exp_instr);
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    check("bp words delivered", got, 3);
    @(negedge clk);
    check("bp no duplicate", out_valid, 0);

    // Random in-range streaming with random backpressure.
    cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    exp_q.delete();
    got = 0; sent = 0; acc = 1'b0;
    for (int c = 0; c < 3000 && got < 100; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      out_ready = 1'($urandom_range(1, 0));
      if (!in_valid && sent < 100) begin
        v.src = 1'($urandom_range(1, 0));
        v.imm = 32'(int'($urandom_range(4095, 0)) - 2048);
        v.rs1 = 5'($urandom_range(31, 0));
        v.rr  = 5'($urandom_range(31, 0));
        v.f3  = 3'($urandom_range(7, 0));
        v.op  = v.src ? OPC_STORE : OPC_OP_IMM;
        v.exp_instr = '0;
        v.oor = 1'b0;
        drive(v);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(v);
        sent++;
        acc = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream unexpected word", out_instr, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stream word%0d", got), decode(out_instr, out_imm_src), fields(e));
        end
        got++;
      end
    end
    in_valid = 1'b0;
    check("stream words delivered", got, 100);
    @(posedge clk); #1;
    check("stream enc_count", enc_count, 100);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    @(posedge clk); #1 in_valid = 1'b0;
    check("rstmid full in_ready", in_ready, 0);
    check("rstmid full out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid out_valid", out_valid, 0);
    check("rstmid enc_count", enc_count, 0);
    check("rstmid rej_count", rej_count, 0);
    check("rstmid in_ready", in_ready, 1);
    check("rstmid err_valid", err_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstmid no stale word", out_valid, 0);
    end
    check("rstmid final enc_count", enc_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
